// File: rtl/clint_mc_pkg.sv
// clint_mc_pkg: CSR addresses, trap instruction encodings, cause codes and FSM states
// shared by the core-local interrupt controller.
package clint_mc_pkg;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam int CAUSE_ECALL  = 11;
   localparam int CAUSE_EBREAK = 3;
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   typedef enum logic [2:0] {
      S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET_ST, S_MRET_AS
   } state_e;
   function automatic logic [31:0] csr_addr(input logic [11:0] a);
      return {20'h0, a};
   endfunction
endpackage

// File: rtl/clint_prio_arb.sv
// clint_prio_arb: fixed-priority arbiter, lowest set index wins.
module clint_prio_arb #(
   parameter int NUM_IRQ = 8,
   parameter int IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [IW-1:0]      idx_o,
   output logic [NUM_IRQ-1:0] grant_o
);
   assign valid_o = |req_i;
   assign grant_o = req_i & (~req_i + NUM_IRQ'(1));
   always_comb begin
      idx_o = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (req_i[i]) idx_o = IW'(i);
   end
endmodule

// File: rtl/clint_mc.sv
// clint_mc: core-local interrupt controller; arbitrates traps/interrupts/mret, stalls the
// pipeline, sequences mepc/mstatus/mcause writes and redirects ex to the trap target.
module clint_mc
   import clint_mc_pkg::*;
#(
   parameter int               NUM_IRQ    = 8,
   parameter int               XLEN       = 32,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
   parameter int               CAUSE_BASE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] int_req,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [31:0]        id_inst,
   input  logic               ex_jump_flag,
   input  logic [XLEN-1:0]    ex_jump_addr,
   input  logic [XLEN-1:0]    csr_mtvec,
   input  logic [XLEN-1:0]    csr_mepc,
   input  logic [XLEN-1:0]    csr_mstatus,
   input  logic [NUM_IRQ-1:0] csr_mie,
   output logic               clint_hold_flag,
   output logic               csr_we,
   output logic [31:0]        csr_waddr,
   output logic [XLEN-1:0]    csr_wdata,
   output logic               int_assert,
   output logic [XLEN-1:0]    int_addr,
   output logic [NUM_IRQ-1:0] int_pending
);
   localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   state_e             state_q;
   logic [NUM_IRQ-1:0] hist_q, pend_q, pend_d, eligible, grant, take;
   logic [IW-1:0]      idx;
   logic               arb_v, idle, is_ecall, is_ebreak, is_mret, sync_ev, async_ev, mret_ev, vec;
   logic [XLEN-1:0]    cause_q, target_q, ms_q, wdata_q, addr_q, code, base, epc;
   logic [31:0]        waddr_q;
   logic               we_q, assert_q;

   clint_prio_arb #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_arb (
      .req_i   (eligible),
      .valid_o (arb_v),
      .idx_o   (idx),
      .grant_o (grant)
   );

   assign idle      = state_q == S_IDLE;
   assign is_ecall  = id_inst == INST_ECALL;
   assign is_ebreak = id_inst == INST_EBREAK;
   assign is_mret   = id_inst == INST_MRET;
   assign sync_ev   = idle & (is_ecall | is_ebreak);
   assign async_ev  = idle & ~sync_ev & arb_v & csr_mstatus[MSTATUS_MIE];
   assign mret_ev   = idle & is_mret & ~(arb_v & csr_mstatus[MSTATUS_MIE]);
   assign take      = async_ev ? grant : '0;
   // Level sources track the pin; edge sources hold a latched bit where a fresh edge beats the take.
   assign int_pending = (EDGE_MASK & pend_q) | (~EDGE_MASK & int_req);
   assign pend_d      = EDGE_MASK & ((int_req & ~hist_q) | (pend_q & ~take));
   assign eligible    = int_pending & csr_mie;
   assign code = XLEN'(CAUSE_BASE) + XLEN'(idx);
   assign base = {csr_mtvec[XLEN-1:2], 2'b00};
   assign vec  = csr_mtvec[1:0] == 2'b01;
   assign epc  = ex_jump_flag ? (sync_ev ? ex_jump_addr - XLEN'(4) : ex_jump_addr) : id_pc;
   assign clint_hold_flag = sync_ev | async_ev | mret_ev | ~idle;

   assign csr_we     = we_q;
   assign csr_waddr  = waddr_q;
   assign csr_wdata  = wdata_q;
   assign int_assert = assert_q;
   assign int_addr   = addr_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         hist_q   <= '0;
         pend_q   <= '0;
         cause_q  <= '0;
         target_q <= '0;
         ms_q     <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         assert_q <= 1'b0;
         addr_q   <= '0;
      end else begin
         hist_q   <= int_req;
         pend_q   <= pend_d;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         assert_q <= 1'b0;
         addr_q   <= '0;
         case (state_q)
            S_IDLE: begin
               if (sync_ev | async_ev) begin
                  state_q  <= S_MEPC;
                  we_q     <= 1'b1;
                  waddr_q  <= csr_addr(CSR_MEPC);
                  wdata_q  <= epc;
                  ms_q     <= csr_mstatus;
                  cause_q  <= sync_ev ? (is_ecall ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK))
                                      : {1'b1, code[XLEN-2:0]};
                  target_q <= (async_ev & vec) ? base + (code << 2) : base;
               end else if (mret_ev) begin
                  state_q <= S_MRET_ST;
                  we_q    <= 1'b1;
                  waddr_q <= csr_addr(CSR_MSTATUS);
                  wdata_q <= {csr_mstatus[XLEN-1:8], 1'b1, csr_mstatus[6:4],
                              csr_mstatus[MSTATUS_MPIE], csr_mstatus[2:0]};
               end
            end
            S_MEPC: begin
               state_q <= S_MSTATUS;
               we_q    <= 1'b1;
               waddr_q <= csr_addr(CSR_MSTATUS);
               wdata_q <= {ms_q[XLEN-1:8], ms_q[MSTATUS_MIE], ms_q[6:4], 1'b0, ms_q[2:0]};
            end
            S_MSTATUS: begin
               state_q <= S_MCAUSE;
               we_q    <= 1'b1;
               waddr_q <= csr_addr(CSR_MCAUSE);
               wdata_q <= cause_q;
            end
            S_MCAUSE: begin
               state_q  <= S_ASSERT;
               assert_q <= 1'b1;
               addr_q   <= target_q;
            end
            S_MRET_ST: begin
               state_q  <= S_MRET_AS;
               assert_q <= 1'b1;
               addr_q   <= csr_mepc;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
